flag_branch_unit: RTL and testbench
===================================

// Module: flag_branch_unit
// PURPOSE
//  Consumer end of the ALU flag interface: latches zr/neg/ov from the writeback stage into the
//  architectural flag register, tracks in-flight flag-writing instructions, and resolves
//  conditional branches against the flags once they are valid. Sits between ID (branch requests)
//  and WB (flag writes); produces a registered taken/target result for the fetch stage.
// PARAMETERS
//  MAX_PEND  3   maximum flag-writing instructions in flight (issued, not yet written back)
//  CNT_W     2   width of pending counter; must satisfy 2**CNT_W > MAX_PEND
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  fw_issue     in   1   flag-writing instr leaves ID this cycle (counted only when ~fw_full)
//  fw_full      out  1   pending count == MAX_PEND; ID must hold further flag writers
//  wb_zen       in   1   WB writes Z flag (all ALU ops)
//  wb_nven      in   1   WB writes N and V flags (ADD/SUB only)
//  wb_zr/neg/ov in   1   flag values from WB-stage adder/ALU
//  br_valid     in   1   branch request valid; held with fields stable until accepted
//  br_ready     out  1   unit can accept a branch this cycle
//  br_cond      in   3   000 NEQ,001 EQ,010 GT,011 LT,100 GTE,101 LTE,110 OVFL,111 UNCOND
//  br_pc1       in   16  PC+1 of the branch
//  br_off       in   9   signed word offset
//  res_valid    out  1   one-cycle pulse: branch resolved
//  res_taken    out  1   condition true (valid with res_valid)
//  res_target   out  16  br_pc1 + sext(br_off) if taken, else br_pc1
//  flags        out  3   {zr,neg,ov} architectural flag register
// BEHAVIOUR
//  - Reset: flags=3'b000, pend=0, res_valid=0, res_taken=0, res_target=16'h0000; br_ready=1, fw_full=0.
//  - Flag reg: Z <= wb_zr when wb_zen; N,V <= wb_neg,wb_ov when wb_nven; unselected bits hold.
//  - Pending counter: +1 on (fw_issue & ~fw_full), -1 on (wb_zen|wb_nven); both same cycle -> hold.
//    Decrement at pend==0 is a protocol error: counter holds at 0 (never wraps).
//  - br_ready = (pend==0) | (br_cond==3'b111). UNCOND never waits on flags.
//  - Accept = br_valid & br_ready. Condition evaluated on the registered flags; result
//    registered -> res_valid exactly 1 cycle after accept. Back-to-back accepts allowed.
//  - Conditions: NEQ ~Z; EQ Z; GT ~Z&~N; LT N; GTE Z|~N; LTE N|Z; OVFL V; UNCOND 1.
//  - Target adder is 16-bit modulo (wraps FFFF->0000), no saturation, no flags produced.
//  - Issue and branch same cycle: branch evaluated on current flags only if pend==0 before issue
//    (the issuing instr is younger than the branch).
//  - Reset mid-operation: pending count and in-flight result discarded, res_valid low next edge.
// CONFIGURATION
//  FLAG_FWD_EN defined: br_ready also true when pend==1 and a WB flag write occurs this cycle;
//    condition uses forwarded flags (WB values for enabled bits, register for others). Saves 1 cycle.
//  Not defined: branch waits until pend==0 after the write lands; evaluates on register only.
// STRUCTURE
//  Shared package: br_cond_t enum (8 codes above), FLAG_Z/FLAG_N/FLAG_V bit indices, OFF_W=9.
//  One sub-module: branch_cond_eval (combinational cond x flags -> taken), reused by ID-stage
//  predictor later. Counter, flag register, result register stay in the top module.
// TESTING
//  - Reset then br_valid cond=UNCOND pc1=0x0010 off=-2 -> next cycle res_valid, taken, target=0x000E.
//  - WB wb_zen=1 zr=1; then EQ pc1=0x0100 off=+5 -> taken, 0x0105; NEQ same -> not taken, 0x0100.
//  - fw_issue x3 -> fw_full=1, 4th issue ignored; 3 WB writes -> pend 0, fw_full=0.
//  - pend=1, GT branch held valid: br_ready=0 until WB (N=0,Z=0); without FLAG_FWD_EN accept
//    cycle after WB, with it accept in WB cycle; both -> taken.
//  - wb_zen only, zr=0 after prior N=1,V=1 -> flags=3'b011; OVFL taken, LT taken, LTE taken.
//  - pc1=0xFFFF off=+1 UNCOND -> target 0x0000; assert rst_n low mid-pend -> pend=0, res_valid=0.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// Shared types and constants for the flag/branch unit: condition codes, flag bit positions,
// and the branch offset sign-extension helper.
package flag_branch_unit_pkg;

  typedef enum logic [2:0] {
    COND_NEQ    = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GTE    = 3'b100,
    COND_LTE    = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } br_cond_t;

  // Flag register layout is {zr, neg, ov}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam int OFF_W = 9;
  localparam int PC_W  = 16;

  function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bundle between ID/WB/fetch and the flag/branch unit. The unit itself uses the slave modport;
// the stage driving issue, writeback and branch requests uses master.
interface flag_branch_unit_if;
  import flag_branch_unit_pkg::*;

  logic                fw_issue;
  logic                fw_full;
  logic                wb_zen;
  logic                wb_nven;
  logic                wb_zr;
  logic                wb_neg;
  logic                wb_ov;
  logic                br_valid;
  logic                br_ready;
  br_cond_t            br_cond;
  logic [PC_W-1:0]     br_pc1;
  logic [OFF_W-1:0]    br_off;
  logic                res_valid;
  logic                res_taken;
  logic [PC_W-1:0]     res_target;
  logic [2:0]          flags;

  modport master (
    output fw_issue, wb_zen, wb_nven, wb_zr, wb_neg, wb_ov,
           br_valid, br_cond, br_pc1, br_off,
    input  fw_full, br_ready, res_valid, res_taken, res_target, flags
  );

  modport slave (
    input  fw_issue, wb_zen, wb_nven, wb_zr, wb_neg, wb_ov,
           br_valid, br_cond, br_pc1, br_off,
    output fw_full, br_ready, res_valid, res_taken, res_target, flags
  );

endinterface

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Pure combinational branch condition evaluator: condition code x {zr,neg,ov} -> taken.
// Kept stateless so an ID-stage predictor can reuse it.
module branch_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  br_cond_t   cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);

  logic z, n, v;

  assign z = flags_i[FLAG_Z];
  assign n = flags_i[FLAG_N];
  assign v = flags_i[FLAG_V];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_NEQ:    taken_o = ~z;
      COND_EQ:     taken_o = z;
      COND_GT:     taken_o = ~z & ~n;
      COND_LT:     taken_o = n;
      COND_GTE:    taken_o = z | ~n;
      COND_LTE:    taken_o = n | z;
      COND_OVFL:   taken_o = v;
      COND_UNCOND: taken_o = 1'b1;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, in-flight flag-writer counter and registered branch resolution.
// Optional build macro FLAG_FWD_EN: resolve a branch in the same cycle as the last pending flag write.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input logic               clk,
  input logic               rst_n,
  flag_branch_unit_if.slave fb
);

  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic [PC_W-1:0]  res_target_q, res_target_d;

  logic             wb_wr;
  logic             fw_full;
  logic             cnt_inc;
  logic             br_ready;
  logic             accept;
  logic [2:0]       eval_flags;
  logic             cond_taken;
  logic [PC_W-1:0]  tgt_sum;

  assign wb_wr   = fb.wb_zen | fb.wb_nven;
  assign fw_full = (pend_q == CNT_W'(MAX_PEND));
  assign cnt_inc = fb.fw_issue & ~fw_full;

  always_comb begin
    flags_d = flags_q;
    if (fb.wb_zen) flags_d[FLAG_Z] = fb.wb_zr;
    if (fb.wb_nven) begin
      flags_d[FLAG_N] = fb.wb_neg;
      flags_d[FLAG_V] = fb.wb_ov;
    end
  end

  // A writeback with nothing pending is a protocol error; saturate at zero instead of wrapping.
  always_comb begin
    pend_d = pend_q;
    if (cnt_inc && !wb_wr)
      pend_d = pend_q + CNT_W'(1);
    else if (!cnt_inc && wb_wr && (pend_q != '0))
      pend_d = pend_q - CNT_W'(1);
  end

`ifdef FLAG_FWD_EN
  // flags_d is exactly the register merged with this cycle's WB write.
  assign eval_flags = flags_d;
  assign br_ready   = (pend_q == '0) || (fb.br_cond == COND_UNCOND) ||
                      ((pend_q == CNT_W'(1)) && wb_wr);
`else
  assign eval_flags = flags_q;
  assign br_ready   = (pend_q == '0) || (fb.br_cond == COND_UNCOND);
`endif

  assign accept  = fb.br_valid & br_ready;
  assign tgt_sum = fb.br_pc1 + sext_off(fb.br_off);

  branch_cond_eval u_cond_eval (
    .cond_i  (fb.br_cond),
    .flags_i (eval_flags),
    .taken_o (cond_taken)
  );

  always_comb begin
    res_valid_d  = accept;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    if (accept) begin
      res_taken_d  = cond_taken;
      res_target_d = cond_taken ? tgt_sum : fb.br_pc1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= 3'b000;
      pend_q       <= '0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
    end else begin
      flags_q      <= flags_d;
      pend_q       <= pend_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
    end
  end

  assign fb.fw_full    = fw_full;
  assign fb.br_ready   = br_ready;
  assign fb.res_valid  = res_valid_q;
  assign fb.res_taken  = res_taken_q;
  assign fb.res_target = res_target_q;
  assign fb.flags      = flags_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: directed scenarios plus random traffic against a
// behavioural model of flags, pending count and branch conditions.
module tb_flag_branch_unit;
  import flag_branch_unit_pkg::*;

  localparam int MAXP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flag_branch_unit_if bus ();

  flag_branch_unit #(.MAX_PEND(MAXP), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fb    (bus)
  );

  typedef struct {
    int          due;
    bit          tk;
    logic [15:0] tgt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit m_z, m_n, m_v;
  int m_pend;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_true(input int c, input bit z, input bit n, input bit v);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] branch_dest(input logic [15:0] pc, input logic [8:0] off);
    int s;
    int sum;
    s   = off[8] ? int'(off) - 512 : int'(off);
    sum = ((int'(pc) + s) % 65536 + 65536) % 65536;
    return sum[15:0];
  endfunction

  task automatic idle_inputs();
    bus.fw_issue = 0; bus.wb_zen = 0; bus.wb_nven = 0;
    bus.wb_zr = 0; bus.wb_neg = 0; bus.wb_ov = 0;
    bus.br_valid = 0; bus.br_cond = COND_NEQ; bus.br_pc1 = '0; bus.br_off = '0;
  endtask

  task automatic model_reset();
    m_z = 0; m_n = 0; m_v = 0; m_pend = 0;
    sb.delete();
  endtask

  // One clock of stimulus: inputs applied at the falling edge, committed at the next rising edge.
  task automatic step(input bit iss, input bit zen, input bit nven, input bit zr, input bit ng,
                      input bit ov, input bit bv, input logic [2:0] cond, input logic [15:0] pc,
                      input logic [8:0] off, output bit acc);
    bit wr, rdy, tk, ez, en, ev;
    exp_t e;
    @(negedge clk);
    chk("flags", 32'(bus.flags), 32'({m_z, m_n, m_v}));
    bus.fw_issue = iss; bus.wb_zen = zen; bus.wb_nven = nven;
    bus.wb_zr = zr; bus.wb_neg = ng; bus.wb_ov = ov;
    bus.br_valid = bv; bus.br_cond = br_cond_t'(cond); bus.br_pc1 = pc; bus.br_off = off;
    #1;
    wr  = zen || nven;
    rdy = (m_pend == 0) || (cond == 3'd7);
    ez = m_z; en = m_n; ev = m_v;
`ifdef FLAG_FWD_EN
    if (m_pend == 1 && wr) rdy = 1'b1;
    if (zen) ez = zr;
    if (nven) begin en = ng; ev = ov; end
`endif
    chk("br_ready", 32'(bus.br_ready), 32'(rdy));
    chk("fw_full", 32'(bus.fw_full), 32'(m_pend == MAXP));
    acc = bv && rdy;
    if (acc) begin
      tk    = cond_true(int'(cond), ez, en, ev);
      e.due = cyc + 1;
      e.tk  = tk;
      e.tgt = tk ? branch_dest(pc, off) : pc;
      sb.push_back(e);
    end
    if (zen) m_z = zr;
    if (nven) begin m_n = ng; m_v = ov; end
    if (iss && m_pend != MAXP && !wr) m_pend++;
    else if (wr && !(iss && m_pend != MAXP) && m_pend > 0) m_pend--;
  endtask

  task automatic idle_step();
    bit a;
    step(0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
  endtask

  // Holds a branch request until accepted, with an optional writeback on a chosen cycle.
  task automatic hold_branch(input logic [2:0] cond, input logic [15:0] pc, input logic [8:0] off,
                             input int wb_cycle, input bit zr, input bit ng, input bit ov,
                             output int waited);
    bit a;
    waited = 0;
    a = 0;
    while (!a && waited < 20) begin
      if (waited == wb_cycle) step(0, 1, 1, zr, ng, ov, 1, cond, pc, off, a);
      else                    step(0, 0, 0, 0, 0, 0, 1, cond, pc, off, a);
      if (!a) waited++;
    end
    if (!a) chk("hold_timeout", 32'(waited), 32'(-1));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("res_missing", 32'(bus.res_valid), 32'(1));
        void'(sb.pop_front());
      end
      if (bus.res_valid) begin
        if (sb.size() == 0) begin
          chk("res_spurious", 32'(bus.res_valid), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_latency", 32'(cyc), 32'(e.due));
          chk("res_taken", 32'(bus.res_taken), 32'(e.tk));
          chk("res_target", 32'(bus.res_target), 32'(e.tgt));
        end
      end
    end
  end

  initial begin
    bit a;
    int w;
    bit hv;
    logic [2:0]  rc;
    logic [15:0] rpc;
    logic [8:0]  roff;

    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_flags", 32'(bus.flags), 32'(0));
    chk("rst_res_valid", 32'(bus.res_valid), 32'(0));
    chk("rst_res_taken", 32'(bus.res_taken), 32'(0));
    chk("rst_res_target", 32'(bus.res_target), 32'(0));
    chk("rst_fw_full", 32'(bus.fw_full), 32'(0));
    chk("rst_br_ready", 32'(bus.br_ready), 32'(1));

    // UNCOND with negative offset
    step(0, 0, 0, 0, 0, 0, 1, 3'd7, 16'h0010, 9'h1FE, a);
    idle_step();

    // Z set, then EQ taken / NEQ not taken
    step(0, 1, 0, 1, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    step(0, 0, 0, 0, 0, 0, 1, 3'd1, 16'h0100, 9'd5, a);
    step(0, 0, 0, 0, 0, 0, 1, 3'd0, 16'h0100, 9'd5, a);
    idle_step();

    // Fill the pending counter; fourth issue must be dropped
    repeat (4) step(1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    idle_step();
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    idle_step();

    // GT held while a flag writer is in flight
    step(1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    hold_branch(3'd2, 16'h0200, 9'd16, 2, 1'b0, 1'b0, 1'b0, w);
`ifdef FLAG_FWD_EN
    chk("gt_wait", 32'(w), 32'(2));
`else
    chk("gt_wait", 32'(w), 32'(3));
`endif
    idle_step();

    // N=1,V=1 then Z-only write of 0
    step(1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    step(0, 1, 1, 1, 1, 1, 0, 3'd0, 16'h0, 9'h0, a);
    step(1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    step(0, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    @(negedge clk);
    chk("flags_011", 32'(bus.flags), 32'(3'b011));
    step(0, 0, 0, 0, 0, 0, 1, 3'd6, 16'h0300, 9'h1F0, a);
    step(0, 0, 0, 0, 0, 0, 1, 3'd3, 16'h0300, 9'd7, a);
    step(0, 0, 0, 0, 0, 0, 1, 3'd5, 16'h0300, 9'd255, a);

    // Target wrap
    step(0, 0, 0, 0, 0, 0, 1, 3'd7, 16'hFFFF, 9'd1, a);
    idle_step();

    // Reset while a result is in flight and writers are pending
    step(1, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 9'h0, a);
    step(1, 0, 0, 0, 0, 0, 1, 3'd7, 16'h1234, 9'd3, a);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_res_valid", 32'(bus.res_valid), 32'(0));
    chk("midrst_fw_full", 32'(bus.fw_full), 32'(0));
    chk("midrst_flags", 32'(bus.flags), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1, 3'd2, 16'h0400, 9'd2, a);
    chk("midrst_accept", 32'(a), 32'(1));
    idle_step();

    // Random traffic
    hv = 0; rc = '0; rpc = '0; roff = '0;
    repeat (500) begin
      bit iss, zen, nven;
      int k;
      if (!hv && ($urandom % 2 == 0)) begin
        hv   = 1;
        rc   = 3'($urandom_range(0, 7));
        rpc  = 16'($urandom);
        roff = 9'($urandom);
      end
      iss = ($urandom % 3 == 0);
      zen = 0; nven = 0;
      if (m_pend > 0 && ($urandom % 3 == 0)) begin
        k = $urandom_range(0, 2);
        zen  = (k != 1);
        nven = (k != 0);
      end
      step(iss, zen, nven, 1'($urandom), 1'($urandom), 1'($urandom), hv, rc, rpc, roff, a);
      if (a) hv = 0;
    end

    repeat (3) idle_step();
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
